// File: rtl/lsu_wb_skid_stage_pkg.sv
// Shared definitions for the LSU-to-writeback skid stage: payload widths,
// reset/idle constants, the writeback packet layout and occupancy states.
package lsu_wb_skid_stage_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 5;
    localparam int WB_CW = 12;

    // Register address presented on rd_a_o while the stage is idle.
    localparam logic [WB_AW-1:0] NOP_RA    = '0;
    localparam logic [WB_DW-1:0] ZERO_WORD = '0;
    localparam logic [WB_CW-1:0] ZERO_CSRA = '0;

    typedef struct packed {
        logic             rd_we;
        logic [WB_AW-1:0] rd_wa;
        logic [WB_DW-1:0] rd_wd;
        logic             csr_we;
        logic [WB_CW-1:0] csr_wa;
        logic [WB_DW-1:0] csr_wd;
    } wb_pkt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/lsu_wb_skid_stage_buf.sv
// Generic one- or two-entry valid/ready pipeline buffer.
// Build option SKID_BUF_EN: adds a skid register so up_ready is a flop
// (not-TWO) and no combinational path exists from dn_ready to up_ready.
// Without it a single register is used and up_ready = empty || dn_ready.
//
// state     | meaning
// ----------+------------------------------------------------------------
// OCC_EMPTY | nothing held, dn_valid low
// OCC_ONE   | main register holds the packet shown downstream
// OCC_TWO   | main shown downstream, skid holds the next one (skid build)
module pipe_skid_buf
    import lsu_wb_skid_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    occ_state_e       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             up_xfer, dn_xfer;

`ifdef SKID_BUF_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
`else
    logic             init_q;
`endif

    assign dn_valid = (state_q != OCC_EMPTY);
    assign dn_data  = main_q;
    assign up_xfer  = up_valid && up_ready;
    assign dn_xfer  = dn_valid && dn_ready;

`ifdef SKID_BUF_EN
    assign up_ready = ready_q;
`else
    // init_q keeps ready low until the first edge after reset release.
    assign up_ready = init_q && ((state_q == OCC_EMPTY) || dn_ready);
`endif

    // Occupancy transitions and register load selection.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef SKID_BUF_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (up_xfer) begin
                        main_d  = up_data;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (up_xfer) begin
`ifdef SKID_BUF_EN
                        if (dn_xfer) begin
                            main_d = up_data;
                        end else begin
                            skid_d  = up_data;
                            state_d = OCC_TWO;
                        end
`else
                        // Accepting in ONE implies dn_ready, so main drains now.
                        main_d = up_data;
`endif
                    end else if (dn_xfer) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
`ifdef SKID_BUF_EN
                    if (dn_xfer) begin
                        main_d  = skid_q;
                        state_d = OCC_ONE;
                    end
`else
                    state_d = OCC_EMPTY;
`endif
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= OCC_EMPTY;
            main_q  <= '0;
`ifdef SKID_BUF_EN
            skid_q  <= '0;
            ready_q <= 1'b0;
`else
            init_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef SKID_BUF_EN
            skid_q  <= skid_d;
            ready_q <= (state_d != OCC_TWO);
`else
            init_q  <= 1'b1;
`endif
        end
    end

endmodule

// File: rtl/lsu_wb_skid_stage.sv
// LSU-to-writeback register stage with retired-instruction counting.
// Build option SKID_BUF_EN selects the two-entry skid buffer (registered
// ready_o); otherwise a single register with combinational ready_o.
// Payload is zeroed whenever valid_o is low; writes to x0 are suppressed.
module lsu_wb_skid_stage
    import lsu_wb_skid_stage_pkg::*;
#(
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    parameter int CW    = WB_CW,
    parameter int CNT_W = 64
) (
    input  logic             ck_i,
    input  logic             rs_n_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             rd_we_i,
    input  logic [AW-1:0]    rd_wa_i,
    input  logic [DW-1:0]    rd_wd_i,
    input  logic             csr_we_i,
    input  logic [CW-1:0]    csr_wa_i,
    input  logic [DW-1:0]    csr_wd_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             rd_we_o,
    output logic [AW-1:0]    rd_a_o,
    output logic [DW-1:0]    rd_wd_o,
    output logic             csr_we_o,
    output logic [CW-1:0]    csr_wa_o,
    output logic [DW-1:0]    csr_wd_o,
    output logic             instret_incr_o,
    output logic [CNT_W-1:0] instret_cnt_o
);

    localparam int               PKT_W   = $bits(wb_pkt_t);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wb_pkt_t          pkt_in;
    wb_pkt_t          pkt_out;
    logic             buf_valid;
    logic             dn_xfer;
    logic [CNT_W-1:0] cnt_q;

    // Pack the incoming LSU fields into the shared packet layout.
    always_comb begin
        pkt_in        = '0;
        pkt_in.rd_we  = rd_we_i;
        pkt_in.rd_wa  = rd_wa_i;
        pkt_in.rd_wd  = rd_wd_i;
        pkt_in.csr_we = csr_we_i;
        pkt_in.csr_wa = csr_wa_i;
        pkt_in.csr_wd = csr_wd_i;
    end

    pipe_skid_buf #(
        .WIDTH (PKT_W)
    ) u_buf (
        .clk_sys  (ck_i),
        .rst_b    (rs_n_i),
        .flush    (flush_i),
        .up_valid (valid_i),
        .up_ready (ready_o),
        .up_data  (pkt_in),
        .dn_valid (buf_valid),
        .dn_ready (ready_i),
        .dn_data  (pkt_out)
    );

    assign dn_xfer        = buf_valid && ready_i;
    assign valid_o        = buf_valid;
    assign instret_incr_o = dn_xfer;
    assign instret_cnt_o  = cnt_q;

    // Idle gating of the payload and x0 write suppression.
    always_comb begin
        rd_we_o  = 1'b0;
        rd_a_o   = NOP_RA;
        rd_wd_o  = ZERO_WORD;
        csr_we_o = 1'b0;
        csr_wa_o = ZERO_CSRA;
        csr_wd_o = ZERO_WORD;
        if (buf_valid) begin
            rd_we_o  = pkt_out.rd_we && (pkt_out.rd_wa != NOP_RA);
            rd_a_o   = pkt_out.rd_wa;
            rd_wd_o  = pkt_out.rd_wd;
            csr_we_o = pkt_out.csr_we;
            csr_wa_o = pkt_out.csr_wa;
            csr_wd_o = pkt_out.csr_wd;
        end
    end

    // Retired-instruction counter; a flush does not cancel a same-edge retire.
    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (!rs_n_i) begin
            cnt_q <= '0;
        end else if (dn_xfer) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule

// File: doc/lsu_wb_skid_stage.md
LSU_WB_SKID_STAGE -- requirements
Module: lsu_wb_skid_stage

Interface
REQ-001 SHALL have parameter DW, default 32, GPR/CSR data width.
REQ-002 SHALL have parameter AW, default 5, GPR address width.
REQ-003 SHALL have parameter CW, default 12, CSR address width.
REQ-004 SHALL have parameter CNT_W, default 64, retired-instruction counter width.
REQ-005 SHALL have ports, in this order (name, direction, width, meaning); one clock, reset asynchronous active-low:
- ck_i  in  1  clock.
- rs_n_i  in  1  async active-low reset.
- flush_i  in  1  synchronous pipeline flush.
- valid_i  in  1  LSU packet valid.
- ready_o  out  1  stage can accept.
- rd_we_i  in  1  GPR write enable.
- rd_wa_i  in  AW  GPR address.
- rd_wd_i  in  DW  GPR data.
- csr_we_i  in  1  CSR write enable.
- csr_wa_i  in  CW  CSR address.
- csr_wd_i  in  DW  CSR data.
- valid_o  out  1  WB packet valid.
- ready_i  in  1  WB accepts.
- rd_we_o  out  1  GPR write enable.
- rd_a_o  out  AW  GPR address.
- rd_wd_o  out  DW  GPR data.
- csr_we_o  out  1  CSR write enable.
- csr_wa_o  out  CW  CSR address.
- csr_wd_o  out  DW  CSR data.
- instret_incr_o  out  1  one-cycle retire pulse.
- instret_cnt_o  out  CNT_W  retired count.

Function
REQ-006 SHALL define upstream transfer as valid_i&&ready_o and downstream transfer as valid_o&&ready_i, both at the rising edge of ck_i.
REQ-007 SHALL deliver packets in order, with no loss and no duplication.
REQ-008 SHALL have 1-cycle latency: a packet accepted into an empty stage appears on the outputs in the next cycle.
REQ-009 SHALL force rd_we_o=0 when the stored rd_wa equals 0, so writes to x0 are suppressed.
REQ-010 SHALL drive every payload output to zero (rd_a_o to the NOP register address) whenever valid_o=0.
REQ-011 SHALL compute instret_incr_o combinationally as valid_o&&ready_i.
REQ-012 SHALL increment instret_cnt_o by 1 on each downstream transfer, wrapping from all-ones to 0.
REQ-013 SHALL on flush_i=1:
- clear all entries at the next edge;
- discard any simultaneous upstream transfer;
- still count a simultaneous downstream transfer.
REQ-014 SHALL keep held payload stable while valid_o=1 and ready_i=0.
REQ-015 SHALL implement occupancy state machine EMPTY/ONE/TWO:
- EMPTY->ONE on upstream transfer.
- ONE->TWO on upstream transfer without downstream transfer.
- ONE->EMPTY on downstream transfer without upstream transfer.
- TWO->ONE on downstream transfer.
- any state->EMPTY on flush_i.

Reset
REQ-016 SHALL, while rs_n_i=0 and independent of clock:
- set state to EMPTY;
- set valid_o=0 and instret_cnt_o=0;
- set all payload outputs to zero, rd_a_o to the NOP register address;
- set ready_o=0.
REQ-017 SHALL assert ready_o=1 from the first edge after rs_n_i deasserts.
REQ-018 SHALL discard any in-flight packet when reset asserts mid-operation.

Configuration
REQ-019 SHALL, with SKID_BUF_EN defined:
- use a main register plus a skid register (states EMPTY/ONE/TWO);
- register ready_o as not-TWO;
- give full throughput with no combinational path from ready_i to ready_o.
REQ-020 SHALL, without SKID_BUF_EN:
- use a single register (state TWO unreachable);
- set ready_o = (state==EMPTY) || ready_i, combinationally.

Structure
REQ-021 SHALL take the following from the shared defines package:
- NOP register address, zero word, CSR address width;
- wb_pkt typedef {rd_we, rd_wa, rd_wd, csr_we, csr_wa, csr_wd}.
REQ-022 SHALL instantiate one generic sub-module pipe_skid_buf (parameter WIDTH) holding the packed payload; the counter and x0 gating stay in the top module.

Verification
REQ-023 SHALL cover a single packet: valid_i=1, rd_wa=3, rd_wd=0xDEADBEEF, ready_i=1 -> next cycle valid_o=1, rd_a_o=3, rd_wd_o=0xDEADBEEF, instret_incr_o=1, instret_cnt_o=1 one cycle later.
REQ-024 SHALL cover backpressure: ready_i=0 with 3 back-to-back packets A,B,C and SKID_BUF_EN defined -> A,B stored, ready_o=0, C held; after ready_i=1, outputs A,B,C in order.
REQ-025 SHALL cover x0 gating: rd_we_i=1, rd_wa_i=0, rd_wd_i=0x55 -> rd_we_o=0 while valid_o=1.
REQ-026 SHALL cover flush: state TWO plus simultaneous valid_i=1 and flush_i=1 -> next cycle valid_o=0, state EMPTY, new packet discarded.
REQ-027 SHALL cover counter wrap: CNT_W=4, 16 transfers -> instret_cnt_o wraps from 15 to 0.
REQ-028 SHALL cover mid-operation reset: rs_n_i=0 pulsed asynchronously while state ONE -> valid_o=0 immediately, and count 0 at that point.
